// File: rtl/aes_host_driver.sv
// Host-side initiator for the AES-128 core: loads key/plaintext words, waits the
// core's fixed latency, captures the ciphertext and streams it back as 32-bit words.
module aes_host_driver #(
    parameter int unsigned LATENCY = 21
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_key,
    input  logic [31:0]   in_data,
    output logic [127:0]  aes_state,
    output logic [127:0]  aes_key,
    input  logic [127:0]  aes_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          busy,
    output logic [15:0]   enc_count
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BEAT_W = 2;
    localparam int unsigned ENC_W  = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_UNLOAD = 2'd2;

    logic [1:0]        state_q, state_nxt;
    logic [BEAT_W-1:0] beat_cnt, beat_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_nxt;
    logic [BLK_W-1:0]  result, result_nxt;
    logic [BLK_W-1:0]  aes_state_nxt, aes_key_nxt;
    logic [WORD_W-1:0] out_data_nxt;
    logic [ENC_W-1:0]  enc_count_nxt;
    logic              in_ready_nxt, out_valid_nxt, busy_nxt;
    logic              in_hs, out_hs;

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    // Next-state and registered-output logic
    always_comb begin
        state_nxt     = state_q;
        beat_nxt      = beat_cnt;
        wait_nxt      = wait_cnt;
        result_nxt    = result;
        aes_state_nxt = aes_state;
        aes_key_nxt   = aes_key;
        out_data_nxt  = out_data;
        enc_count_nxt = enc_count;
        in_ready_nxt  = in_ready;
        out_valid_nxt = out_valid;
        busy_nxt      = busy;

        case (state_q)
            ST_IDLE: begin
                in_ready_nxt = 1'b1;
                if (in_hs) begin
                    if (in_key) begin
                        aes_key_nxt = {aes_key[BLK_W-WORD_W-1:0], in_data};
                    end else begin
                        aes_state_nxt = {aes_state[BLK_W-WORD_W-1:0], in_data};
                        if (beat_cnt == BEAT_W'(3)) begin
                            beat_nxt     = '0;
                            wait_nxt     = CNT_W'(LATENCY - 32'd1);
                            state_nxt    = ST_WAIT;
                            in_ready_nxt = 1'b0;
                            busy_nxt     = 1'b1;
                        end else begin
                            beat_nxt = beat_cnt + BEAT_W'(1);
                        end
                    end
                end
            end
            ST_WAIT: begin
                in_ready_nxt = 1'b0;
                if (wait_cnt == '0) begin
                    result_nxt    = aes_out;
                    out_data_nxt  = aes_out[BLK_W-1 -: WORD_W];
                    enc_count_nxt = enc_count + ENC_W'(1);
                    out_valid_nxt = 1'b1;
                    state_nxt     = ST_UNLOAD;
                end else begin
                    wait_nxt = wait_cnt - CNT_W'(1);
                end
            end
            ST_UNLOAD: begin
                if (out_hs) begin
                    result_nxt   = {result[BLK_W-WORD_W-1:0], WORD_W'(0)};
                    out_data_nxt = result[BLK_W-WORD_W-1 -: WORD_W];
                    if (beat_cnt == BEAT_W'(3)) begin
                        beat_nxt      = '0;
                        state_nxt     = ST_IDLE;
                        out_valid_nxt = 1'b0;
                        in_ready_nxt  = 1'b1;
                        busy_nxt      = 1'b0;
                    end else begin
                        beat_nxt = beat_cnt + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                beat_nxt      = '0;
                wait_nxt      = '0;
                in_ready_nxt  = 1'b0;
                out_valid_nxt = 1'b0;
                busy_nxt      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            beat_cnt  <= '0;
            wait_cnt  <= '0;
            result    <= '0;
            aes_state <= '0;
            aes_key   <= '0;
            out_data  <= '0;
            enc_count <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            beat_cnt  <= beat_nxt;
            wait_cnt  <= wait_nxt;
            result    <= result_nxt;
            aes_state <= aes_state_nxt;
            aes_key   <= aes_key_nxt;
            out_data  <= out_data_nxt;
            enc_count <= enc_count_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_aes_host_driver.sv
// Directed bench for aes_host_driver: one instance at LATENCY=21, one at LATENCY=1,
// each fed by a behavioural stand-in for the AES core.
module tb_aes_host_driver;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h0123456789abcdeffedcba9876543210;

    // Interleaved traffic: five key words (first is overwritten) and four plaintext words
    localparam logic [31:0] IL_DATA [9] = '{32'hdeadbeef, 32'h01234567, 32'h2b7e1516,
                                           32'h28aed2a6, 32'h89abcdef, 32'habf71588,
                                           32'hfedcba98, 32'h09cf4f3c, 32'h76543210};
    localparam bit IL_KEY [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam int IL_GAP [9] = '{0, 2, 1, 0, 3, 1, 0, 2, 1};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel = 1'b0;
    logic in_valid = 1'b0, in_key = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic [31:0] cyc = '0;
    logic [31:0] hs_cyc = '0;
    int checks = 0;
    int failures = 0;

    logic          a_in_ready, a_out_valid, a_busy, b_in_ready, b_out_valid, b_busy;
    logic [31:0]   a_out_data, b_out_data;
    logic [15:0]   a_enc_count, b_enc_count;
    logic [127:0]  a_aes_state, a_aes_key, a_aes_out, b_aes_state, b_aes_key, b_aes_out;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        if (pt == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return pt ^ {k[63:0], k[127:64]} ^ 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696;
    endfunction

    // Core stand-ins; the short-latency core also mixes in the cycle count to expose the capture edge
    assign a_aes_out = aes_ref(a_aes_state, a_aes_key);
    assign b_aes_out = aes_ref(b_aes_state, b_aes_key) ^ {96'h0, cyc};

    wire cur_in_ready         = sel ? b_in_ready  : a_in_ready;
    wire cur_out_valid        = sel ? b_out_valid : a_out_valid;
    wire cur_busy             = sel ? b_busy      : a_busy;
    wire [31:0] cur_out_data  = sel ? b_out_data  : a_out_data;
    wire [15:0] cur_enc_count = sel ? b_enc_count : a_enc_count;

    aes_host_driver #(.LATENCY(21)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_key(in_key), .in_data(in_data),
        .aes_state(a_aes_state), .aes_key(a_aes_key), .aes_out(a_aes_out),
        .out_valid(a_out_valid), .out_ready(out_ready & ~sel), .out_data(a_out_data),
        .busy(a_busy), .enc_count(a_enc_count)
    );

    aes_host_driver #(.LATENCY(1)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_key(in_key), .in_data(in_data),
        .aes_state(b_aes_state), .aes_key(b_aes_key), .aes_out(b_aes_out),
        .out_valid(b_out_valid), .out_ready(out_ready & sel), .out_data(b_out_data),
        .busy(b_busy), .enc_count(b_enc_count)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One write beat; entered and left at a falling edge
    task automatic put(input logic k, input logic [31:0] d);
        int n;
        in_valid = 1'b1;
        in_key   = k;
        in_data  = d;
        n = 0;
        while (!cur_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("put_timeout", 128'(n), 128'd0);
        @(posedge clk);
        #1 hs_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic put_block(input logic k, input logic [127:0] blk);
        logic [127:0] sh;
        sh = blk;
        for (int i = 0; i < 4; i++) begin
            put(k, sh[127:96]);
            sh = sh << 32;
        end
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!cur_out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 128'(cyc - hs_cyc), 128'(exp_lat));
        check({tag, "_busy"}, 128'(cur_busy), 128'd1);
    endtask

    // Drains four read beats, optionally stalling 10 cycles before word stall_at
    task automatic get_block(input string tag, input logic [127:0] exp, input int stall_at);
        logic [127:0] sh;
        logic [31:0]  held;
        int n;
        sh = exp;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!cur_out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (i == stall_at) begin
                out_ready = 1'b0;
                held = cur_out_data;
                repeat (10) begin
                    @(negedge clk);
                    if (cur_out_data !== held || !cur_out_valid) n = 99;
                end
                check($sformatf("%s_stall_hold", tag), 128'(n), 128'(0));
            end
            check($sformatf("%s_w%0d", tag, i), 128'(cur_out_data), 128'(sh[127:96]));
            check($sformatf("%s_rdy%0d", tag, i), 128'(cur_in_ready), 128'd0);
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            sh = sh << 32;
        end
        check({tag, "_busy_end"}, 128'(cur_busy), 128'd0);
        check({tag, "_valid_end"}, 128'(cur_out_valid), 128'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 128'(a_in_ready), 128'd0);
        check("rst_out_valid", 128'(a_out_valid), 128'd0);
        check("rst_busy", 128'(a_busy), 128'd0);
        check("rst_enc_count", 128'(a_enc_count), 128'd0);
        check("rst_key", a_aes_key, 128'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 128'(a_in_ready), 128'd1);

        // FIPS-197 vector
        put_block(1'b1, FIPS_KEY);
        put_block(1'b0, FIPS_PT);
        check("fips_state", a_aes_state, FIPS_PT);
        wait_valid("fips", 21);
        get_block("fips", FIPS_CT, -1);
        check("fips_count", 128'(a_enc_count), 128'd1);
        check("fips_ready_back", 128'(a_in_ready), 128'd1);

        // Key reuse
        put_block(1'b0, FIPS_PT);
        wait_valid("reuse", 21);
        get_block("reuse", FIPS_CT, -1);
        check("reuse_count", 128'(a_enc_count), 128'd2);

        // Interleaved, gapped writes; writes offered during WAIT must be ignored
        for (int i = 0; i < 9; i++) begin
            repeat (IL_GAP[i]) @(negedge clk);
            put(IL_KEY[i], IL_DATA[i]);
        end
        in_valid = 1'b1;
        in_key   = 1'b1;
        in_data  = 32'hfeedface;
        wait_valid("inter", 21);
        in_valid = 1'b0;
        check("inter_key", a_aes_key, K2);
        check("inter_state", a_aes_state, P2);
        get_block("inter", aes_ref(P2, K2), 1);
        check("inter_count", 128'(a_enc_count), 128'd3);

        // Asynchronous reset during WAIT
        put_block(1'b0, FIPS_PT);
        repeat (5) @(negedge clk);
        check("mid_busy", 128'(a_busy), 128'd1);
        #1 rst = 1'b0;
        #1;
        check("mid_in_ready", 128'(a_in_ready), 128'd0);
        check("mid_busy_rst", 128'(a_busy), 128'd0);
        check("mid_count", 128'(a_enc_count), 128'd0);
        check("mid_key", a_aes_key, 128'd0);
        check("mid_state", a_aes_state, 128'd0);
        check("mid_out", {95'd0, a_out_valid, a_out_data}, 128'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 check("mid_ready_after", 128'(a_in_ready), 128'd1);
        @(negedge clk);
        put_block(1'b1, FIPS_KEY);
        put_block(1'b0, FIPS_PT);
        wait_valid("reload", 21);
        get_block("reload", FIPS_CT, -1);
        check("reload_count", 128'(a_enc_count), 128'd1);

        // LATENCY=1 instance: capture happens on the edge right after the 4th plaintext beat
        sel = 1'b1;
        @(negedge clk);
        put_block(1'b1, K2);
        put_block(1'b0, P2);
        wait_valid("lat1", 1);
        get_block("lat1", aes_ref(P2, K2) ^ {96'h0, hs_cyc}, -1);
        check("lat1_count", 128'(b_enc_count), 128'd1);

        // Counter wrap via backdoor preload
        force u_b.enc_count = 16'hffff;
        @(posedge clk);
        #1 release u_b.enc_count;
        @(negedge clk);
        check("wrap_preload", 128'(cur_enc_count), 128'hffff);
        put_block(1'b0, P2);
        wait_valid("wrap", 1);
        check("wrap_count", 128'(b_enc_count), 128'd0);
        get_block("wrap", aes_ref(P2, K2) ^ {96'h0, hs_cyc}, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_host_driver.md
# aes_host_driver

Host-side initiator for the AES-128 encryption core in the Trojan-benchmark test top. Accepts a 128-bit key and plaintext as 32-bit words over a valid/ready write channel and drives them onto the core's `state`/`key` buses. It then waits the core's fixed pipeline latency, captures the 128-bit ciphertext, and returns it as four 32-bit words over a valid/ready read channel. It is the bench- and FPGA-side counterpart that feeds and drains the `top` block.

## Interface
- `LATENCY`, 21: edges from the accepting edge of the 4th state beat to the edge that captures `aes_out`; legal range 1..255.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: write beat offered.
- `in_ready` output 1: driver can accept a write beat.
- `in_key` input 1: beat tag; 1 = key word, 0 = plaintext word.
- `in_data` input 32: write word, most-significant word first.
- `aes_state` output 128: plaintext bus to the AES core.
- `aes_key` output 128: key bus to the AES core.
- `aes_out` input 128: ciphertext bus from the AES core.
- `out_valid` output 1: ciphertext word available.
- `out_ready` input 1: consumer accepts the ciphertext word.
- `out_data` output 32: ciphertext word, most-significant word first.
- `busy` output 1: high in WAIT and UNLOAD.
- `enc_count` output 16: count of completed captures; wraps.

## Operation
- **FSM states:** IDLE, WAIT, UNLOAD.
- **Reset values:** FSM = IDLE. `in_ready`, `out_valid`, `busy` = 0. `aes_state`, `aes_key`, `out_data`, `enc_count` = 0. Internal state-beat count and wait counter = 0.
- **IDLE:**
  - `in_ready` = 1.
  - Write handshake = `in_valid` & `in_ready`.
  - Key beat: `aes_key` <= {`aes_key`[95:0], `in_data`}.
  - Plaintext beat: `aes_state` <= {`aes_state`[95:0], `in_data`}, and the state-beat count increments.
  - Key and plaintext beats may interleave freely.
  - The key persists across encryptions and is never cleared except by reset. Re-keying is optional; after a partial key reload the last four key words form the key.
- **IDLE -> WAIT:** on the 4th plaintext handshake. The state-beat count clears and the wait counter loads `LATENCY`-1.
- **WAIT:**
  - `in_ready` = 0. `aes_state` and `aes_key` are held stable.
  - The counter decrements each edge.
  - On the edge where the counter is 0: result register <= `aes_out`, `enc_count` += 1 (0xFFFF -> 0x0000), go to UNLOAD.
- **UNLOAD:**
  - `out_valid` = 1, `out_data` = result[127:96].
  - Each read handshake shifts the result left 32 bits.
  - On the 4th handshake go to IDLE; `out_valid` falls and `in_ready` rises on that same edge.
  - `out_ready` stalls are unbounded; `out_data` is held while `out_ready` = 0.
- `in_valid` while `in_ready` = 0 is ignored, with no side effects.
- **Reset mid-operation:** asynchronous return to reset values. Any in-flight ciphertext is discarded and the key is lost.

## Timing
- `in_ready`, `out_valid`, `busy` and `out_data` are registered, with no combinational path from inputs to outputs.
- `in_ready` first rises on the first rising edge after `rst` deasserts.
- **Encrypt latency:** let t be the edge accepting the 4th plaintext beat.
  - `aes_state` holds the new plaintext after t.
  - `aes_out` is captured at edge t+`LATENCY`.
  - `out_valid` is high from t+`LATENCY` onward.
- **Minimum turnaround:** 4 input beats + `LATENCY` + 4 output beats. With back-to-back handshakes that is `LATENCY`+8 edges per block.
- `busy` equals the FSM being in WAIT or UNLOAD, registered alongside the FSM.

## Test plan
- **FIPS-197 vector:** after reset, key beats 00010203, 04050607, 08090a0b, 0c0d0e0f; plaintext 00112233, 44556677, 8899aabb, ccddeeff. Read beats must be 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, with `out_valid` first high at t+21. Then `enc_count` = 1 and `busy` = 0.
- **Key reuse:** immediately send the same plaintext with no key beats. The same ciphertext must be returned and `enc_count` = 2.
- **Interleaved and throttled traffic:** interleaved key/plaintext beats with random `in_valid` gaps, plus `out_ready` held low for 10 cycles mid-unload. `out_data` must stay stable while stalled, the ciphertext must match the reference model, and `in_ready` must be 0 throughout WAIT and UNLOAD.
- **Reset mid-operation:**
  - Assert `rst` low during WAIT, asynchronously between edges. All outputs must go to reset values immediately, `in_ready` must be 1 one edge after release, and `aes_key` must be 0.
  - A new full load must then produce the correct ciphertext.
- **Counter wrap:** force `enc_count` to 0xFFFF via 65535 encryptions (or a backdoor preload). The next capture must produce 0x0000.
- **Parameter sweep:** with `LATENCY` = 1, the capture must occur at edge t+1 and the ciphertext must equal `aes_out` sampled at that edge.
